ai_action_sched: RTL and testbench

AI_ACTION_SCHED -- requirements
Module: ai_action_sched

---
 rtl/ai_action_sched.sv | 150 +++++++++++++++
 tb/tb_ai_action_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ai_action_sched.sv
// AI action scheduler: LFSR-driven action picker with ready/busy handshake and frame-counted hold.
// Optional build macro AI_NO_REPEAT_EN bumps a pick that would repeat the last committed action.
module ai_action_sched #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned MIN_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        busy,
  input  logic        action_ready,
  output logic [2:0]  action,
  output logic        action_valid,
  output logic [4:0]  hold_left,
  output logic [15:0] lfsr_q
);

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  MIN_HOLD_W = 5'(MIN_HOLD);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PICK      = 3'd1;
  localparam logic [2:0] ST_OFFER     = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  action_q, action_d;
  logic        valid_q, valid_d;
  logic [4:0]  hold_q, hold_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] lfsr_d;
  logic [2:0]  pick_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  assign lfsr_d       = lfsr_next(lfsr_q);
  assign action       = action_q;
  assign action_valid = valid_q;
  assign hold_left    = hold_q;

  // Candidate action for the PICK cycle, optionally steered away from a repeat.
  always_comb begin
    pick_s = lfsr_q[10:8];
`ifdef AI_NO_REPEAT_EN
    if (lfsr_q[10:8] == last_q) begin
      pick_s = lfsr_q[10:8] + 3'd1;
    end else begin
      pick_s = lfsr_q[10:8];
    end
`endif
  end

  // Next-state logic for the scheduler FSM and its registered outputs.
  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        action_d = 3'b000;
        valid_d  = 1'b0;
        hold_d   = 5'd0;
        last_d   = 3'b000;
        if (enable) begin
          state_d = ST_PICK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PICK: begin
        action_d = pick_s;
        hold_d   = MIN_HOLD_W + 5'({1'b0, lfsr_q[3:0]});
        valid_d  = 1'b1;
        state_d  = ST_OFFER;
      end
      ST_OFFER: begin
        if (action_ready && !busy) begin
          valid_d = 1'b0;
          last_d  = action_q;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_OFFER;
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          hold_d = hold_q - 5'd1;
          if (hold_q == 5'd1) begin
            state_d = busy ? ST_WAIT_BUSY : ST_PICK;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT_BUSY: begin
        hold_d = 5'd0;
        if (!busy) begin
          state_d = ST_PICK;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        action_d = 3'b000;
        valid_d  = 1'b0;
        hold_d   = 5'd0;
        last_d   = 3'b000;
      end
    endcase
    // Losing enable wins over any transfer or expiry decided above.
    if (!enable && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      action_d = 3'b000;
      valid_d  = 1'b0;
      hold_d   = 5'd0;
      last_d   = last_q;
    end else begin
      state_d  = state_d;
    end
  end

  // State, output and LFSR registers; the LFSR free-runs in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      action_q <= 3'b000;
      valid_q  <= 1'b0;
      hold_q   <= 5'd0;
      last_q   <= 3'b000;
      lfsr_q   <= SEED_EFF;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_ai_action_sched.sv
// Directed scoreboard bench for ai_action_sched; steers picks by predicting the LFSR.
module tb_ai_action_sched;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        enable;
  logic        busy;
  logic        action_ready;
  logic [2:0]  action;
  logic        action_valid;
  logic [4:0]  hold_left;
  logic [15:0] lfsr_q;

  typedef struct packed {
    logic [2:0] act;
    logic [4:0] hold;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [2:0]  last_commit;
  logic [2:0]  held_act;
  logic [4:0]  exp_hold;
  logic        found;

  ai_action_sched #(.SEED(16'h0000), .MIN_HOLD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .busy         (busy),
    .action_ready (action_ready),
    .action       (action),
    .action_valid (action_valid),
    .hold_left    (hold_left),
    .lfsr_q       (lfsr_q)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Reference LFSR, reset to the zero-seed substitute value.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'h0001;
    else       m_lfsr <= nxt(m_lfsr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("lfsr", {16'h0, lfsr_q}, {16'h0, m_lfsr});
  endtask

  // Expected result of a PICK happening on the next cycle.
  task automatic push_pick();
    logic [15:0] p;
    exp_t e;
    p = nxt(m_lfsr);
    e.act = p[10:8];
`ifdef AI_NO_REPEAT_EN
    if (p[10:8] == last_commit) e.act = p[10:8] + 3'd1;
`endif
    e.hold = 5'd4 + {1'b0, p[3:0]};
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_act"}, {29'h0, action}, {29'h0, e.act});
      chk({tag, "_hold"}, {27'h0, hold_left}, {27'h0, e.hold});
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; frame_tick = 1'b0; enable = 1'b0;
    busy = 1'b0; action_ready = 1'b0; last_commit = 3'd0;
    #12;
    chk("rst_lfsr", {16'h0, lfsr_q}, 32'h0000_0001);
    chk("rst_act", {29'h0, action}, 32'h0);
    chk("rst_valid", {31'h0, action_valid}, 32'h0);
    chk("rst_hold", {27'h0, hold_left}, 32'h0);
    #10;
    chk("rst_lfsr_held", {16'h0, lfsr_q}, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;

    // Wait in IDLE until the next PICK will yield action 7 with hold 5.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (nxt(m_lfsr)[10:8] == 3'd7 && nxt(m_lfsr)[3:0] == 4'd1) found = 1'b1;
      else cyc();
    end
    chk("steer_a", {31'h0, found}, 32'h1);
    chk("idle_valid", {31'h0, action_valid}, 32'h0);
    enable = 1'b1; action_ready = 1'b1; busy = 1'b0;
    push_pick();
    cyc();
    chk("pick_valid", {31'h0, action_valid}, 32'h0);
    cyc();
    chk("offer_valid", {31'h0, action_valid}, 32'h1);
    pop_cmp("offer1");
    last_commit = action;
    cyc();
    chk("valid_one_cycle", {31'h0, action_valid}, 32'h0);
    chk("hold_act", {29'h0, action}, 32'h7);
    chk("hold_start", {27'h0, hold_left}, 32'h5);
    action_ready = 1'b0;

    // Five ticks with idle gaps; busy high on the last one.
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      busy = (i == 4);
      cyc();
      frame_tick = 1'b0;
      chk("hold_dec", {27'h0, hold_left}, 32'(4 - i));
      cyc();
      chk("hold_gap", {27'h0, hold_left}, 32'(4 - i));
      chk("hold_novalid", {31'h0, action_valid}, 32'h0);
    end

    // In WAIT_BUSY: release busy only when the next pick repeats action 7.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (nxt(m_lfsr)[10:8] == 3'd7 && nxt(m_lfsr)[3:0] >= 4'd3) found = 1'b1;
      else begin
        cyc();
        chk("wait_nopick", {31'h0, action_valid}, 32'h0);
      end
    end
    chk("steer_b", {31'h0, found}, 32'h1);
    busy = 1'b0;
    push_pick();
    cyc();
    chk("pick2_valid", {31'h0, action_valid}, 32'h0);
    cyc();
    chk("offer2_valid", {31'h0, action_valid}, 32'h1);
`ifdef AI_NO_REPEAT_EN
    chk("norepeat", {29'h0, action}, 32'h0);
`else
    chk("repeat_ok", {29'h0, action}, 32'h7);
`endif
    pop_cmp("offer2");
    held_act = action;
    exp_hold = hold_left;

    // Stall: ready low for 10 cycles, with a stray frame_tick that must be ignored.
    frame_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      frame_tick = 1'b0;
      chk("stall_valid", {31'h0, action_valid}, 32'h1);
      chk("stall_act", {29'h0, action}, {29'h0, held_act});
      chk("stall_hold", {27'h0, hold_left}, {27'h0, exp_hold});
    end
    action_ready = 1'b1; busy = 1'b1;
    cyc();
    chk("busy_blocks", {31'h0, action_valid}, 32'h1);
    busy = 1'b0;
    cyc();
    chk("xfer_valid", {31'h0, action_valid}, 32'h0);
    chk("xfer_act", {29'h0, action}, {29'h0, held_act});
    last_commit = held_act;
    action_ready = 1'b0;

    // Count the hold down to 7, then drop enable on a tick cycle.
    for (int i = 0; i < 20 && exp_hold > 5'd7; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      exp_hold = exp_hold - 5'd1;
      chk("hold2_dec", {27'h0, hold_left}, {27'h0, exp_hold});
      cyc();
    end
    chk("hold_at7", {27'h0, hold_left}, 32'h7);
    frame_tick = 1'b1; enable = 1'b0;
    cyc();
    frame_tick = 1'b0;
    chk("drop_act", {29'h0, action}, 32'h0);
    chk("drop_hold", {27'h0, hold_left}, 32'h0);
    chk("drop_valid", {31'h0, action_valid}, 32'h0);
    cyc();
    chk("idle_stay", {31'h0, action_valid}, 32'h0);
    last_commit = 3'd0;

    // Re-enable where the raw pick is 0: last committed must have cleared in IDLE.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (nxt(m_lfsr)[10:8] == 3'd0) found = 1'b1;
      else cyc();
    end
    chk("steer_c", {31'h0, found}, 32'h1);
    enable = 1'b1; action_ready = 1'b0;
    push_pick();
    cyc();
    cyc();
    chk("offer3_valid", {31'h0, action_valid}, 32'h1);
    pop_cmp("offer3");
    action_ready = 1'b1; busy = 1'b0; enable = 1'b0;
    cyc();
    chk("ovr_valid", {31'h0, action_valid}, 32'h0);
    chk("ovr_act", {29'h0, action}, 32'h0);
    chk("ovr_hold", {27'h0, hold_left}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
